core_irq_arbiter: RTL and testbench
===================================

Name: core_irq_arbiter

Overview:
- Parametrised interrupt collector/arbiter that sits between external interrupt lines and the core trap logic.
- Generalises the fixed M/S external/timer/software decode to NUM_SRC sources, each with:
  - a synchroniser,
  - an edge or level trigger mode,
  - a per-source priority,
  - a latched pending bit.
- Presents one registered winner (irq_valid/irq_id) to the CSR/trap path and clears edge-pending state on an acknowledge handshake.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31); source IDs are 1..NUM_SRC, ID 0 = none.
- PRIO_W, 3, priority field width; priority 0 = never interrupts.
- SYNC_STAGES, 2, flip-flop synchroniser depth per source (>=1).
- ID_W, $clog2(NUM_SRC+1), derived; width of the ID fields.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- irq_src  in  NUM_SRC  raw asynchronous interrupt lines; bit i = source ID i+1.
- cfg_enable  in  NUM_SRC  per-source enable.
- cfg_edge  in  NUM_SRC  1 = rising-edge triggered, 0 = level triggered.
- cfg_prio  in  NUM_SRC*PRIO_W  packed priorities; slice i = source i+1.
- cfg_threshold  in  PRIO_W  a source competes only if prio > threshold.
- global_enable  in  1  global gate (from mstatus/priv decode).
- check_interrupt  in  1  controller is at an interruptible boundary.
- irq_valid  out  1  interrupt request to the trap path.
- irq_id  out  ID_W  winning source ID; 0 when none.
- irq_ack  in  1  trap taken for irq_id this cycle.
- pending  out  NUM_SRC  raw pending bits, for the CSR readback.

Behaviour:
- Reset (async, rstn low):
  - Sync chains, edge history, pending, winner register and ack-guard flop all go to 0.
  - irq_valid=0, irq_id=0, pending=0.
  - Release is synchronous to clk.
- Synchroniser: SYNC_STAGES flops per source produce s[i]. An edge-history flop holds s_d[i].
- Pending update, registered every cycle:
  - Level mode: pending[i] <= s[i].
  - Edge mode: pending[i] <= (s[i] & ~s_d[i]) | (pending[i] & ~clr[i]).
  - clr[i] = irq_ack & irq_valid & (irq_id == i+1).
  - If a new rising edge and clr hit the same source in the same cycle, set wins.
  - Level sources ignore ack; they drop only when the line drops.
- Mode change: writing cfg_edge while pending is set leaves pending as-is. It follows the new rule from the next cycle.
- Eligibility: elig[i] = pending[i] & cfg_enable[i] & (prio[i] > cfg_threshold). A prio of 0 is never eligible.
- Arbitration (combinational on elig):
  - Highest prio wins; ties go to the lowest ID.
  - The result is registered into win_id/win_valid each cycle, so there is 1 cycle of latency from pending.
- Latency: a line high at clock edge 0 gives irq_valid high after edge SYNC_STAGES+2, in both modes. With defaults that is after the 4th edge.
- Output:
  - irq_valid = win_valid & global_enable & check_interrupt & ~guard.
  - irq_id = win_id when irq_valid, else 0.
- Ack guard:
  - guard <= irq_ack & irq_valid.
  - This suppresses irq_valid for the one cycle after an ack, while the winner register still holds the stale winner.
- irq_ack while irq_valid=0 is ignored and has no state change.
- Winner update: win_valid/win_id update every cycle regardless of check_interrupt or global_enable. Gating is output-only, so there is no re-arbitration delay when the gate opens.
- Disable mid-pending: clearing cfg_enable hides the source from the next winner-register update. The pending bit is retained (edge mode) and reappears on re-enable.
- Width rules:
  - Priority compare is unsigned PRIO_W bits.
  - The ID is the index+1 zero-extended to ID_W.
- NUM_SRC=1 is legal: ID_W=1.

Test Plan:
- Reset and latency:
  - Stimulus: assert rstn low with irq_src=8'hFF, then release; cfg_enable=FF, cfg_edge=0, all prio=1, threshold=0, global_enable=1, check_interrupt=1.
  - Required: irq_valid=0 and pending=0 during reset; irq_valid=1 with irq_id=1 exactly after the 4th edge following release.
- Priority and tie-break:
  - Stimulus: level sources 3 and 6 high with prio3=5 and prio6=5, then raise prio6 to 6.
  - Required: irq_id=3 first; irq_id=6 two cycles after the prio change.
- Threshold and gating:
  - Stimulus: source 2 at prio=2 with threshold=2; then threshold=1 with check_interrupt=0; then check_interrupt=1.
  - Required: irq_valid stays 0 until check_interrupt=1, then irq_valid=1 combinationally in the same cycle with irq_id=2.
- Edge ack:
  - Stimulus: edge source 4 pulses high for 1 cycle (held over the sync window), then irq_ack is given when irq_valid=1.
  - Required: pending[3] clears the next cycle; irq_valid=0 in the guard cycle and stays 0 afterwards; a level source would remain asserted.
- Simultaneous set and clear:
  - Stimulus: a second rising edge on source 4 reaches s in the same cycle as its ack.
  - Required: pending[3] stays 1; after the guard cycle irq_valid=1 with irq_id=4.
- Async reset mid-operation:
  - Stimulus: drop rstn while irq_valid=1 and pending=8'h28.
  - Required: irq_valid, irq_id and pending go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_irq_arbiter_if.sv
// Interrupt request/acknowledge handshake between the arbiter and the trap path.
// valid/ready rule: the trap path may raise irq_ack only in a cycle where irq_valid is high;
// an ack while irq_valid is low is ignored by the arbiter.
interface core_irq_arbiter_if #(
  parameter int ID_W = 4
) ();
  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;

  modport master (output irq_valid, output irq_id, input irq_ack);
  modport slave  (input irq_valid, input irq_id, output irq_ack);
endinterface

// File: rtl/core_irq_arbiter.sv
// Interrupt collector/arbiter: per-source synchroniser, edge/level pending latch,
// priority arbitration into a registered winner, output gating and a post-ack guard.
module core_irq_arbiter #(
  parameter int NUM_SRC     = 8,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = $clog2(NUM_SRC + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_SRC-1:0]        irq_src,
  input  logic [NUM_SRC-1:0]        cfg_enable,
  input  logic [NUM_SRC-1:0]        cfg_edge,
  input  logic [NUM_SRC*PRIO_W-1:0] cfg_prio,
  input  logic [PRIO_W-1:0]         cfg_threshold,
  input  logic                      global_enable,
  input  logic                      check_interrupt,
  core_irq_arbiter_if.master        irq_if,
  output logic [NUM_SRC-1:0]        pending
);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
  logic [NUM_SRC-1:0] sdel_q, sdel_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               win_valid_q, win_valid_d;
  logic [ID_W-1:0]    win_id_q, win_id_d;
  logic               guard_q, guard_d;

  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic               irq_valid;
  logic [ID_W-1:0]    irq_id;
  logic [PRIO_W-1:0]  best_prio;

  assign s = sync_q[SYNC_STAGES-1];

  // Gating is output-only so the winner register is already current when the gate opens.
  assign irq_valid        = win_valid_q & global_enable & check_interrupt & ~guard_q;
  assign irq_id           = irq_valid ? win_id_q : '0;
  assign irq_if.irq_valid = irq_valid;
  assign irq_if.irq_id    = irq_id;
  assign pending          = pending_q;

  always_comb begin
    sync_d[0] = irq_src;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    sdel_d = s;
  end

  always_comb begin
    pending_d = pending_q;
    clr       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = irq_if.irq_ack & irq_valid & (irq_id == ID_W'(i + 1));
      // A fresh rising edge outranks a clear landing in the same cycle.
      if (cfg_edge[i]) begin
        pending_d[i] = (s[i] & ~sdel_q[i]) | (pending_q[i] & ~clr[i]);
      end else begin
        pending_d[i] = s[i];
      end
    end
    guard_d = irq_if.irq_ack & irq_valid;
  end

  always_comb begin
    elig        = '0;
    best_prio   = '0;
    win_valid_d = 1'b0;
    win_id_d    = '0;
    // Strict greater-than while scanning upward keeps ties on the lowest ID.
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = pending_q[i] & cfg_enable[i] &
                (cfg_prio[i*PRIO_W +: PRIO_W] > cfg_threshold);
      if (elig[i] && (!win_valid_d || (cfg_prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
        win_valid_d = 1'b1;
        win_id_d    = ID_W'(i + 1);
        best_prio   = cfg_prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      sdel_q      <= '0;
      pending_q   <= '0;
      win_valid_q <= 1'b0;
      win_id_q    <= '0;
      guard_q     <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      sdel_q      <= sdel_d;
      pending_q   <= pending_d;
      win_valid_q <= win_valid_d;
      win_id_q    <= win_id_d;
      guard_q     <= guard_d;
    end
  end

endmodule

// File: tb/tb_core_irq_arbiter.sv
// Bench for core_irq_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the pending/arbitration/gating rules.
module tb_core_irq_arbiter;
  localparam int N    = 8;
  localparam int PW   = 3;
  localparam int SYNC = 2;
  localparam int IDW  = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  irq_src;
  logic [N-1:0]  cfg_enable;
  logic [N-1:0]  cfg_edge;
  logic [N*PW-1:0] cfg_prio;
  logic [PW-1:0] cfg_threshold;
  logic          global_enable;
  logic          check_interrupt;
  logic [N-1:0]  pending;

  int n_cmp = 0;
  int n_err = 0;

  core_irq_arbiter_if #(.ID_W(IDW)) irq_if ();

  core_irq_arbiter #(.NUM_SRC(N), .PRIO_W(PW), .SYNC_STAGES(SYNC)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .irq_src         (irq_src),
    .cfg_enable      (cfg_enable),
    .cfg_edge        (cfg_edge),
    .cfg_prio        (cfg_prio),
    .cfg_threshold   (cfg_threshold),
    .global_enable   (global_enable),
    .check_interrupt (check_interrupt),
    .irq_if          (irq_if),
    .pending         (pending)
  );

  always #5 clk = ~clk;

  // Reference model state: the synchronised line is irq_src seen SYNC samples back.
  logic [N-1:0]   m_q[$];
  logic [N-1:0]   m_s, m_sd, m_pend;
  logic           m_win_v, m_guard;
  logic [IDW-1:0] m_win_id;

  function automatic logic m_valid();
    return m_win_v & global_enable & check_interrupt & ~m_guard;
  endfunction

  function automatic logic [IDW-1:0] m_id();
    return m_valid() ? m_win_id : '0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < SYNC; k++) m_q.push_back('0);
    m_s = '0; m_sd = '0; m_pend = '0;
    m_win_v = 1'b0; m_guard = 1'b0; m_win_id = '0;
  endtask

  task automatic model_edge();
    logic           v;
    logic [IDW-1:0] id;
    logic [N-1:0]   np;
    int             best, score, p;
    v    = m_valid();
    id   = m_id();
    best = -1;
    for (int i = 0; i < N; i++) begin
      p = int'(cfg_prio[i*PW +: PW]);
      if (m_pend[i] && cfg_enable[i] && p > int'(cfg_threshold)) begin
        score = p * 64 + (63 - (i + 1));
        if (score > best) best = score;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cfg_edge[i])
        np[i] = (m_s[i] & ~m_sd[i]) | (m_pend[i] & ~(irq_if.irq_ack & v & (int'(id) == i + 1)));
      else
        np[i] = m_s[i];
    end
    m_guard  = irq_if.irq_ack & v;
    m_pend   = np;
    m_win_v  = (best >= 0);
    m_win_id = (best >= 0) ? IDW'(63 - (best % 64)) : '0;
    m_sd     = m_s;
    m_q.push_back(irq_src);
    void'(m_q.pop_front());
    m_s = m_q[0];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_valid", 32'(irq_if.irq_valid), 32'(m_valid()));
    chk("model_id", 32'(irq_if.irq_id), 32'(m_id()));
    chk("model_pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic set_prio(input int src, input int val);
    cfg_prio[(src-1)*PW +: PW] = PW'(val);
  endtask

  initial begin
    int n;
    // Reset and latency
    rstn = 1'b0; irq_src = 8'hFF; cfg_enable = 8'hFF; cfg_edge = 8'h00;
    cfg_threshold = '0; global_enable = 1'b1; check_interrupt = 1'b1;
    irq_if.irq_ack = 1'b0;
    for (int i = 1; i <= N; i++) set_prio(i, 1);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(irq_if.irq_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    rstn = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("lat_early_valid", 32'(irq_if.irq_valid), 32'd0);
    end
    step();
    chk("lat_valid", 32'(irq_if.irq_valid), 32'd1);
    chk("lat_id", 32'(irq_if.irq_id), 32'd1);

    // Priority and tie-break
    irq_src = 8'h24; set_prio(3, 5); set_prio(6, 5);
    repeat (6) step();
    chk("tie_id", 32'(irq_if.irq_id), 32'd3);
    set_prio(6, 6);
    repeat (2) step();
    chk("prio_id", 32'(irq_if.irq_id), 32'd6);

    // Threshold and gating
    irq_src = 8'h02; set_prio(2, 2); cfg_threshold = 3'd2;
    repeat (6) step();
    chk("thr_valid", 32'(irq_if.irq_valid), 32'd0);
    cfg_threshold = 3'd1; check_interrupt = 1'b0;
    repeat (4) step();
    chk("gate_valid", 32'(irq_if.irq_valid), 32'd0);
    check_interrupt = 1'b1;
    #1;
    chk("gate_open_valid", 32'(irq_if.irq_valid), 32'd1);
    chk("gate_open_id", 32'(irq_if.irq_id), 32'd2);

    // Edge ack
    irq_src = 8'h00; cfg_threshold = '0; cfg_edge = 8'h08; set_prio(4, 3);
    repeat (4) step();
    irq_src = 8'h08;
    repeat (3) step();
    irq_src = 8'h00;
    n = 0;
    while (!irq_if.irq_valid && n < 10) begin step(); n++; end
    chk("edge_wait_valid", 32'(irq_if.irq_valid), 32'd1);
    chk("edge_wait_id", 32'(irq_if.irq_id), 32'd4);
    irq_if.irq_ack = 1'b1;
    step();
    irq_if.irq_ack = 1'b0;
    chk("ack_pending3", 32'(pending[3]), 32'd0);
    chk("ack_guard_valid", 32'(irq_if.irq_valid), 32'd0);
    step();
    chk("ack_after_valid", 32'(irq_if.irq_valid), 32'd0);

    // Simultaneous set and clear
    irq_src = 8'h08;
    repeat (3) step();
    irq_src = 8'h00;
    n = 0;
    while (!irq_if.irq_valid && n < 10) begin step(); n++; end
    chk("sc_wait_valid", 32'(irq_if.irq_valid), 32'd1);
    repeat (2) step();
    irq_src = 8'h08;
    step();
    step();
    irq_if.irq_ack = 1'b1;
    step();
    irq_if.irq_ack = 1'b0;
    chk("sc_pending3", 32'(pending[3]), 32'd1);
    chk("sc_guard_valid", 32'(irq_if.irq_valid), 32'd0);
    step();
    chk("sc_valid", 32'(irq_if.irq_valid), 32'd1);
    chk("sc_id", 32'(irq_if.irq_id), 32'd4);
    irq_src = 8'h00;

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      irq_src         = N'($urandom);
      irq_if.irq_ack  = ($urandom_range(0, 2) == 0);
      global_enable   = ($urandom_range(0, 3) != 0);
      check_interrupt = ($urandom_range(0, 3) != 0);
      if ((t % 16) == 0) begin
        cfg_enable    = N'($urandom);
        cfg_edge      = N'($urandom);
        cfg_prio      = (N*PW)'($urandom);
        cfg_threshold = PW'($urandom_range(0, 3));
      end
      step();
    end

    // Async reset mid-operation
    irq_if.irq_ack = 1'b0; global_enable = 1'b1; check_interrupt = 1'b1;
    cfg_edge = 8'h00; cfg_enable = 8'hFF; cfg_threshold = '0;
    set_prio(4, 3); set_prio(6, 6); irq_src = 8'h28;
    repeat (6) step();
    chk("pre_rst_pending", 32'(pending), 32'h28);
    chk("pre_rst_valid", 32'(irq_if.irq_valid), 32'd1);
    chk("pre_rst_id", 32'(irq_if.irq_id), 32'd6);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(irq_if.irq_valid), 32'd0);
    chk("arst_id", 32'(irq_if.irq_id), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    model_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
